// File: rtl/lcd_frame_serializer.sv
// -----------------------------------------------------------------------------
// lcd_frame_serializer
//
// Takes a coherent snapshot of the LCD debug fields driven by the design under
// test and streams it to the host link as a byte frame over a valid/ready
// handshake. A frame is started by a `start` pulse or by the refresh timer.
//
// Frame layout (defaults give 46 bytes):
//   0                     header 0xA5
//   1                     pc
//   2 .. 1+IB             instruction, MSB byte first (IB = NINSTR_BITS/8)
//   next 6                SrcA, SrcB, ALUResult, Result, WriteData, ReadData
//   next 1                flags {4'b0, MemWrite, Branch, MemtoReg, RegWrite}
//   next NREGS            registrador[0] .. registrador[NREGS-1]
//   last                  XOR of every byte except the header and itself
//
// Ports:
//   clk_2, reset_n          clock (rising edge) and async active-low reset
//   start                   frame request, sampled only while idle
//   lcd_*                   live debug fields, captured on the trigger edge
//   tx_data/tx_valid/tx_ready  byte stream to the host
//   busy                    high while a frame is being sent
//   frame_done              one-cycle pulse after the checksum is accepted
// -----------------------------------------------------------------------------
module lcd_frame_serializer #(
    parameter int unsigned NBITS          = 8,
    parameter int unsigned NREGS          = 32,
    parameter int unsigned NINSTR_BITS    = 32,
    parameter int unsigned REFRESH_CYCLES = 0
) (
    input  logic                   clk_2,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [NINSTR_BITS-1:0] lcd_instruction,
    input  logic [NBITS-1:0]       lcd_registrador [0:NREGS-1],
    input  logic [NBITS-1:0]       lcd_pc,
    input  logic [NBITS-1:0]       lcd_SrcA,
    input  logic [NBITS-1:0]       lcd_SrcB,
    input  logic [NBITS-1:0]       lcd_ALUResult,
    input  logic [NBITS-1:0]       lcd_Result,
    input  logic [NBITS-1:0]       lcd_WriteData,
    input  logic [NBITS-1:0]       lcd_ReadData,
    input  logic                   lcd_MemWrite,
    input  logic                   lcd_Branch,
    input  logic                   lcd_MemtoReg,
    input  logic                   lcd_RegWrite,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   frame_done
);

    // Byte positions inside the frame.
    localparam int InstrBytes = int'(NINSTR_BITS / 8);
    localparam int InstrBase  = 2;
    localparam int DpBase     = InstrBase + InstrBytes;
    localparam int FlagIdx    = DpBase + 6;
    localparam int RegBase    = FlagIdx + 1;
    localparam int CsumIdx    = RegBase + int'(NREGS);
    localparam int FrameLen   = CsumIdx + 1;
    localparam int IdxW       = $clog2(FrameLen);
    localparam int CntW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [7:0]      Header  = 8'hA5;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(CsumIdx);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;

    // Snapshot of the debug fields, frozen for the duration of a frame.
    logic [NBITS-1:0]       r_pc;
    logic [NINSTR_BITS-1:0] r_instr;
    logic [NBITS-1:0]       r_dp   [0:5];
    logic [3:0]             r_flags;
    logic [NBITS-1:0]       r_regs [0:NREGS-1];

    logic [IdxW-1:0]        r_idx;
    logic [7:0]             r_csum;
    logic [CntW-1:0]        r_cnt;
    logic                   r_done;

    logic                   w_refresh_hit;
    logic                   w_trigger;
    logic                   w_xfer;
    logic                   w_last;
    logic [7:0]             w_byte;
    int                     w_idx;

    // -------------------------------------------------------------------------
    // Trigger and handshake decode
    // -------------------------------------------------------------------------
    assign w_refresh_hit = (REFRESH_CYCLES > 0) && (r_cnt == CntW'(REFRESH_CYCLES - 1));
    assign w_trigger     = (r_state == StIdle) && (start || w_refresh_hit);
    assign w_xfer        = (r_state == StSend) && tx_ready;
    assign w_last        = (r_idx == LastIdx);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_trigger) begin
                    w_state_next = StSend;
                end
            end
            StSend: begin
                if (w_xfer && w_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // Byte selection from the snapshot; the checksum slot reads the running XOR
    // -------------------------------------------------------------------------
    always_comb begin
        w_idx  = int'(r_idx);
        w_byte = r_csum;
        if (w_idx == 0) begin
            w_byte = Header;
        end
        if (w_idx == 1) begin
            w_byte = r_pc;
        end
        for (int b = 0; b < InstrBytes; b++) begin
            if (w_idx == InstrBase + b) begin
                w_byte = r_instr[NINSTR_BITS-1-8*b -: 8];
            end
        end
        for (int d = 0; d < 6; d++) begin
            if (w_idx == DpBase + d) begin
                w_byte = r_dp[d];
            end
        end
        if (w_idx == FlagIdx) begin
            w_byte = {4'b0000, r_flags};
        end
        for (int r = 0; r < int'(NREGS); r++) begin
            if (w_idx == RegBase + r) begin
                w_byte = r_regs[r];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Snapshot, byte index, checksum, refresh timer, done pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_flags <= '0;
            for (int d = 0; d < 6; d++) begin
                r_dp[d] <= '0;
            end
            for (int r = 0; r < int'(NREGS); r++) begin
                r_regs[r] <= '0;
            end
            r_idx   <= '0;
            r_csum  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_trigger) begin
                r_pc    <= lcd_pc;
                r_instr <= lcd_instruction;
                r_dp[0] <= lcd_SrcA;
                r_dp[1] <= lcd_SrcB;
                r_dp[2] <= lcd_ALUResult;
                r_dp[3] <= lcd_Result;
                r_dp[4] <= lcd_WriteData;
                r_dp[5] <= lcd_ReadData;
                r_flags <= {lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite};
                for (int r = 0; r < int'(NREGS); r++) begin
                    r_regs[r] <= lcd_registrador[r];
                end
                r_idx   <= '0;
                r_csum  <= '0;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IdxW'(1);
                    // Header is not part of the checksum.
                    if (r_idx != '0) begin
                        r_csum <= r_csum ^ w_byte;
                    end
                end
            end

            r_done <= w_xfer && w_last;

            // Timer runs only while idle and waiting; any trigger or frame clears it.
            if ((REFRESH_CYCLES > 0) && (r_state == StIdle) && !w_trigger) begin
                r_cnt <= r_cnt + CntW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tx_valid   = (r_state == StSend);
    assign busy       = (r_state == StSend);
    assign tx_data    = (r_state == StSend) ? w_byte : 8'h00;
    assign frame_done = r_done;

endmodule
